// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op at a time from execute, checks alignment,
// issues a single bus beat with lane-steered data/strobes, and returns an extended
// load result (or error) to writeback as a one-cycle pulse.
module load_store_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // execute-side request
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  // writeback-side response
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  // memory bus
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid
);

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  typedef enum logic [1:0] {StIdle, StReq, StWaitR, StResp} state_e;

  state_e            state_q, state_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  logic              accept;
  logic              req_misaligned;
  logic              in_req;
  logic [31:0]       lane;
  logic [31:0]       load_data;
  logic [3:0]        strb;
  logic [31:0]       wdata_rep;

  assign accept = req_valid && (state_q == StIdle);
  assign in_req = (state_q == StReq);

  // Reserved size or an address that does not sit on the access's natural boundary.
  always_comb begin
    req_misaligned = 1'b0;
    case (req_size)
      SizeByte: req_misaligned = 1'b0;
      SizeHalf: req_misaligned = req_addr[0];
      SizeWord: req_misaligned = (req_addr[1:0] != 2'b00);
      default:  req_misaligned = 1'b1;
    endcase
  end

  // Shift the addressed lane down to bit 0, then sign/zero-extend to 32 bits.
  always_comb begin
    lane      = mem_rdata >> {addr_q[1:0], 3'b000};
    load_data = lane;
    case (size_q)
      SizeByte: load_data = uns_q ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      SizeHalf: load_data = uns_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default:  load_data = lane;
    endcase
  end

  // Byte enables and lane-replicated store data for the registered op.
  always_comb begin
    strb      = 4'b1111;
    wdata_rep = wdata_q;
    case (size_q)
      SizeByte: begin
        strb      = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      SizeHalf: begin
        strb      = 4'b0011 << addr_q[1:0];
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        strb      = 4'b1111;
        wdata_rep = wdata_q;
      end
    endcase
  end

  // Next-state and response capture; rsp fields are zeroed whenever RESP is left.
  always_comb begin
    state_d     = state_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_misaligned) begin
            state_d     = StResp;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (mem_ready) begin
          if (we_q) begin
            state_d     = StResp;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = 32'h0;
          end else if (mem_rvalid) begin
            state_d     = StResp;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = load_data;
          end else begin
            state_d = StWaitR;
          end
        end
      end
      StWaitR: begin
        if (mem_rvalid) begin
          state_d     = StResp;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = load_data;
        end
      end
      StResp: begin
        state_d     = StIdle;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
      end
      default: begin
        state_d     = StIdle;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
      end
    endcase
  end

  // State and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Latch the op on accept; request inputs are ignored until the unit is idle again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
    end
  end

  // Bus outputs come only from registers and are quiet outside REQ.
  always_comb begin
    mem_valid = in_req;
    mem_we    = in_req && we_q;
    mem_addr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem_wstrb = (in_req && we_q) ? strb : 4'b0000;
    mem_wdata = (in_req && we_q) ? wdata_rep : 32'h0;
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int n_tests = 0;
  int n_fail  = 0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op and hold it through one accepting edge, then drop req_valid.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
    check_eq("ready_before_accept", {31'h0, req_ready}, 32'h1);
    step();
    req_valid = 1'b0;
    req_addr  = 32'hDEAD_0003;  // must be ignored after accept
    req_we    = ~we;
  endtask

  initial begin
    int pulses;
    logic [31:0] seen;

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'b00; req_unsigned = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step();
    step();
    check_eq("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check_eq("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    rst_n = 1'b1;
    step();

    // SB 0x1003
    mem_ready = 1'b1;
    issue(1'b1, 32'h0000_1003, 32'h0000_00A5, 2'b00, 1'b0);
    check_eq("sb_mem_valid", {31'h0, mem_valid}, 32'h1);
    check_eq("sb_mem_we", {31'h0, mem_we}, 32'h1);
    check_eq("sb_mem_addr", mem_addr, 32'h0000_1000);
    check_eq("sb_wstrb", {28'h0, mem_wstrb}, 32'h8);
    check_eq("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    check_eq("sb_no_rsp_yet", {31'h0, rsp_valid}, 32'h0);
    step();
    check_eq("sb_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check_eq("sb_rsp_err", {31'h0, rsp_err}, 32'h0);
    check_eq("sb_mem_idle", {31'h0, mem_valid}, 32'h0);
    step();
    check_eq("sb_rsp_one_cycle", {31'h0, rsp_valid}, 32'h0);
    mem_ready = 1'b0;

    // LH / LHU 0x2002 with data on the same cycle as mem_ready
    for (int u = 0; u < 2; u++) begin
      issue(1'b0, 32'h0000_2002, 32'h0, 2'b01, u[0]);
      check_eq("lh_mem_addr", mem_addr, 32'h0000_2000);
      check_eq("lh_wstrb", {28'h0, mem_wstrb}, 32'h0);
      check_eq("lh_mem_we", {31'h0, mem_we}, 32'h0);
      mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h8001_1234;
      step();
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      check_eq("lh_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check_eq(u == 0 ? "lh_rdata" : "lhu_rdata", rsp_rdata,
               u == 0 ? 32'hFFFF_8001 : 32'h0000_8001);
      step();
    end

    // LW 0x3001 misaligned
    issue(1'b0, 32'h0000_3001, 32'h0, 2'b10, 1'b0);
    check_eq("lw_mis_no_bus", {31'h0, mem_valid}, 32'h0);
    check_eq("lw_mis_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check_eq("lw_mis_err", {31'h0, rsp_err}, 32'h1);
    check_eq("lw_mis_rdata", rsp_rdata, 32'h0);
    step();
    check_eq("lw_mis_done", {31'h0, rsp_valid}, 32'h0);

    // LB 0x4001 with bus stalls and late data
    issue(1'b0, 32'h0000_4001, 32'h0, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_eq("lb_stall_valid", {31'h0, mem_valid}, 32'h1);
      check_eq("lb_stall_addr", mem_addr, 32'h0000_4000);
      step();
    end
    mem_ready = 1'b1;
    check_eq("lb_req_valid", {31'h0, mem_valid}, 32'h1);
    check_eq("lb_req_addr", mem_addr, 32'h0000_4000);
    step();
    mem_ready = 1'b0;
    check_eq("lb_wait_no_bus", {31'h0, mem_valid}, 32'h0);
    step();
    check_eq("lb_wait_no_rsp", {31'h0, rsp_valid}, 32'h0);
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_7F00;
    step();
    mem_rvalid = 1'b0;
    pulses = 0; seen = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) begin
        pulses++;
        seen = rsp_rdata;
      end
      step();
    end
    check_eq("lb_pulses", pulses, 32'd1);
    check_eq("lb_rdata", seen, 32'h0000_007F);

    // Reset while waiting for read data
    issue(1'b0, 32'h0000_4001, 32'h0, 2'b00, 1'b0);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rstw_req_ready", {31'h0, req_ready}, 32'h1);
    check_eq("rstw_mem_valid", {31'h0, mem_valid}, 32'h0);
    check_eq("rstw_mem_we", {31'h0, mem_we}, 32'h0);
    check_eq("rstw_wstrb", {28'h0, mem_wstrb}, 32'h0);
    check_eq("rstw_mem_addr", mem_addr, 32'h0);
    check_eq("rstw_mem_wdata", mem_wdata, 32'h0);
    check_eq("rstw_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check_eq("rstw_rsp_err", {31'h0, rsp_err}, 32'h0);
    check_eq("rstw_rsp_rdata", rsp_rdata, 32'h0);
    step();
    #2 rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_rvalid = 1'b0;
    check_eq("rstw_late_rvalid", {31'h0, rsp_valid}, 32'h0);
    check_eq("rstw_idle", {31'h0, req_ready}, 32'h1);
    step();
    check_eq("rstw_late_rvalid2", {31'h0, rsp_valid}, 32'h0);
    check_eq("rstw_rdata_after", rsp_rdata, 32'h0);

    // SW followed by a back-to-back LW held valid
    mem_ready = 1'b1;
    issue(1'b1, 32'h0000_5000, 32'h1122_3344, 2'b10, 1'b0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_6000; req_size = 2'b10;
    check_eq("sw_wstrb", {28'h0, mem_wstrb}, 32'hF);
    check_eq("sw_wdata", mem_wdata, 32'h1122_3344);
    check_eq("sw_busy", {31'h0, req_ready}, 32'h0);
    step();
    check_eq("sw_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check_eq("sw_resp_not_ready", {31'h0, req_ready}, 32'h0);
    step();
    check_eq("lw_b2b_ready", {31'h0, req_ready}, 32'h1);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;  // ignored while idle
    step();
    req_valid = 1'b0;
    check_eq("lw_b2b_mem_valid", {31'h0, mem_valid}, 32'h1);
    check_eq("lw_b2b_mem_addr", mem_addr, 32'h0000_6000);
    check_eq("lw_b2b_no_rsp", {31'h0, rsp_valid}, 32'h0);
    step();
    mem_rvalid = 1'b0;
    check_eq("lw_b2b_rsp", {31'h0, rsp_valid}, 32'h1);
    check_eq("lw_b2b_rdata", rsp_rdata, 32'hDEAD_BEEF);
    step();
    mem_ready = 1'b0;

    // Reserved size
    issue(1'b0, 32'h0000_7000, 32'h0, 2'b11, 1'b0);
    check_eq("rsv_no_bus", {31'h0, mem_valid}, 32'h0);
    check_eq("rsv_err", {31'h0, rsp_err}, 32'h1);
    step();

    // SH upper half
    mem_ready = 1'b1;
    issue(1'b1, 32'h0000_7002, 32'h1234_BEEF, 2'b01, 1'b0);
    check_eq("sh_wstrb", {28'h0, mem_wstrb}, 32'hC);
    check_eq("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    step();
    check_eq("sh_err", {31'h0, rsp_err}, 32'h0);
    step();

    // LB / LBU top byte
    for (int u = 0; u < 2; u++) begin
      issue(1'b0, 32'h0000_8003, 32'h0, 2'b00, u[0]);
      mem_rvalid = 1'b1; mem_rdata = 32'h8000_0000;
      step();
      mem_rvalid = 1'b0;
      check_eq(u == 0 ? "lb3_rdata" : "lbu3_rdata", rsp_rdata,
               u == 0 ? 32'hFFFF_FF80 : 32'h0000_0080);
      step();
    end
    mem_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
